// File: rtl/pixel_stream_pkg.sv
// Shared types and sizing helpers for the raster pixel-stream source.
package pixel_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBLANK = 3'd2,
    S_ACTIVE = 3'd3,
    S_HBLANK = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int H_PIXEL_DFLT = 640;
  localparam int V_PIXEL_DFLT = 480;
  localparam int H_BLANK_DFLT = 160;
  localparam int LINE_CYC     = H_PIXEL_DFLT + H_BLANK_DFLT;
  localparam int FRAME_PIX    = H_PIXEL_DFLT * V_PIXEL_DFLT;

  function automatic int line_cyc(input int h_pixel, input int h_blank);
    return h_pixel + h_blank;
  endfunction

  function automatic int frame_pix(input int h_pixel, input int v_pixel);
    return h_pixel * v_pixel;
  endfunction

  // Width of a counter that runs 0..limit-1; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/raster_timing.sv
// Frame/line sequencer: FSM, blanking/column/line counters and the raster read address.
module raster_timing
  import pixel_stream_pkg::*;
#(
  parameter int H_PIXEL    = 640,
  parameter int V_PIXEL    = 480,
  parameter int H_BLANK    = 160,
  parameter int V_BLANK    = 2,
  parameter int VSYNC_CYC  = 4,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cont,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  vsync_s0,
  output logic                  href_s0,
  output logic                  done_s0,
  output logic                  busy
);

  localparam int LINE_LEN   = line_cyc(H_PIXEL, H_BLANK);
  localparam int VBLANK_CYC = V_BLANK * LINE_LEN;
  localparam int BLK_MAX    = max3(VSYNC_CYC, H_BLANK, VBLANK_CYC);
  localparam int BW         = cnt_w(BLK_MAX);
  localparam int CW         = cnt_w(H_PIXEL);
  localparam int LW         = cnt_w(V_PIXEL + 1);

  localparam logic [BW-1:0] VS_LAST  = BW'(VSYNC_CYC - 1);
  localparam logic [BW-1:0] VB_LAST  = BW'((VBLANK_CYC > 0) ? VBLANK_CYC - 1 : 0);
  localparam logic [BW-1:0] HB_LAST  = BW'(H_BLANK - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(H_PIXEL - 1);
  localparam logic [LW-1:0] LINE_END = LW'(V_PIXEL);

  state_t          state;
  logic [BW-1:0]   blk_cnt;
  logic [CW-1:0]   col_cnt;
  logic [LW-1:0]   line_cnt;

  // Flags and read strobe are registered together with the state they describe,
  // so each branch sets the flags that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      blk_cnt  <= '0;
      col_cnt  <= '0;
      line_cnt <= '0;
      rd_addr  <= '0;
      rd_en    <= 1'b0;
      vsync_s0 <= 1'b0;
      href_s0  <= 1'b0;
      done_s0  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      vsync_s0 <= 1'b0;
      href_s0  <= 1'b0;
      done_s0  <= 1'b0;
      rd_en    <= 1'b0;
      busy     <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_VSYNC;
            vsync_s0 <= 1'b1;
            blk_cnt  <= '0;
            line_cnt <= '0;
            rd_addr  <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        S_VSYNC: begin
          if (blk_cnt == VS_LAST) begin
            blk_cnt <= '0;
            if (V_BLANK == 0) begin
              state   <= S_ACTIVE;
              href_s0 <= 1'b1;
              rd_en   <= 1'b1;
            end else begin
              state <= S_VBLANK;
            end
          end else begin
            blk_cnt  <= blk_cnt + BW'(1);
            vsync_s0 <= 1'b1;
          end
        end
        S_VBLANK: begin
          if (blk_cnt == VB_LAST) begin
            blk_cnt <= '0;
            state   <= S_ACTIVE;
            href_s0 <= 1'b1;
            rd_en   <= 1'b1;
          end else begin
            blk_cnt <= blk_cnt + BW'(1);
          end
        end
        S_ACTIVE: begin
          if (col_cnt == COL_LAST) begin
            col_cnt  <= '0;
            line_cnt <= line_cnt + LW'(1);
            state    <= S_HBLANK;
          end else begin
            col_cnt <= col_cnt + CW'(1);
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
            href_s0 <= 1'b1;
            rd_en   <= 1'b1;
          end
        end
        S_HBLANK: begin
          if (blk_cnt == HB_LAST) begin
            blk_cnt <= '0;
            if (line_cnt == LINE_END) begin
              state   <= S_DONE;
              done_s0 <= 1'b1;
            end else begin
              state   <= S_ACTIVE;
              rd_addr <= rd_addr + ADDR_WIDTH'(1);
              href_s0 <= 1'b1;
              rd_en   <= 1'b1;
            end
          end else begin
            blk_cnt <= blk_cnt + BW'(1);
          end
        end
        S_DONE: begin
          if (cont) begin
            state    <= S_VSYNC;
            vsync_s0 <= 1'b1;
            line_cnt <= '0;
            rd_addr  <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_gen.sv
// Raster pixel-stream source: sequencer plus a two-stage pipeline aligning flags with RAM data.
module pixel_stream_gen
  import pixel_stream_pkg::*;
#(
  parameter int H_PIXEL    = 640,
  parameter int V_PIXEL    = 480,
  parameter int H_BLANK    = 160,
  parameter int V_BLANK    = 2,
  parameter int VSYNC_CYC  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cont,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  frame_vsync,
  output logic                  frame_href,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  busy,
  output logic                  frame_done
);

  logic vsync_s0, href_s0, done_s0, rd_en_s0;

  raster_timing #(
    .H_PIXEL   (H_PIXEL),
    .V_PIXEL   (V_PIXEL),
    .H_BLANK   (H_BLANK),
    .V_BLANK   (V_BLANK),
    .VSYNC_CYC (VSYNC_CYC),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cont    (cont),
    .rd_en   (rd_en_s0),
    .rd_addr (mem_rd_addr),
    .vsync_s0(vsync_s0),
    .href_s0 (href_s0),
    .done_s0 (done_s0),
    .busy    (busy)
  );

  assign mem_rd_en = rd_en_s0;

  function automatic logic [DATA_WIDTH-1:0] gate_pixel(input logic vld,
                                                       input logic [DATA_WIDTH-1:0] d);
    return vld ? d : '0;
  endfunction

  logic                  vsync_p1, href_p1, done_p1, vld_p1;
  logic                  vsync_p2, href_p2, done_p2, vld_p2;
  logic [DATA_WIDTH-1:0] data_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_p1 <= 1'b0;
      href_p1  <= 1'b0;
      done_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      vsync_p2 <= 1'b0;
      href_p2  <= 1'b0;
      done_p2  <= 1'b0;
      vld_p2   <= 1'b0;
      data_p2  <= '0;
    end else begin
      // stage 1: flags travel while the RAM read is in flight
      vsync_p1 <= vsync_s0;
      href_p1  <= href_s0;
      done_p1  <= done_s0;
      vld_p1   <= href_s0 & rd_en_s0;
      // stage 2: RAM data is valid now; register it beside its flags
      vsync_p2 <= vsync_p1;
      href_p2  <= href_p1;
      done_p2  <= done_p1;
      vld_p2   <= vld_p1;
      data_p2  <= gate_pixel(vld_p1, mem_rd_data);
    end
  end

  assign frame_vsync = vsync_p2;
  assign frame_href  = href_p2;
  assign pix_valid   = vld_p2;
  assign pix_data    = data_p2;
  assign frame_done  = done_p2;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Self-checking bench for pixel_stream_gen: two geometries against a frame-level reference model.
module tb_pixel_stream_gen;

  localparam int HP = 4, VP = 3, VS = 3;
  localparam int HB_A = 2, VB_A = 1;
  localparam int HB_B = 1, VB_B = 0;
  localparam int NPIX = HP * VP;
  localparam int MAXC = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, start_a = 1'b0, cont_a = 1'b0;
  logic        rst_b = 1'b1, start_b = 1'b0, cont_b = 1'b0;
  logic        en_a, vs_a, hr_a, pv_a, fd_a, busy_a;
  logic        en_b, vs_b, hr_b, pv_b, fd_b, busy_b;
  logic [18:0] addr_a, addr_b;
  logic [7:0]  rdata_a, rdata_b, pd_a, pd_b;
  logic [7:0]  ram_a [NPIX];
  logic [7:0]  ram_b [NPIX];

  int checks = 0;
  int errors = 0;

  logic        o_vs [MAXC], o_hr [MAXC], o_pv [MAXC], o_fd [MAXC], o_busy [MAXC], o_en [MAXC];
  logic [7:0]  o_pd [MAXC];
  logic [18:0] o_addr [MAXC];

  pixel_stream_gen #(.H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(HB_A), .V_BLANK(VB_A),
                     .VSYNC_CYC(VS), .DATA_WIDTH(8), .ADDR_WIDTH(19)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .cont(cont_a),
    .mem_rd_en(en_a), .mem_rd_addr(addr_a), .mem_rd_data(rdata_a),
    .frame_vsync(vs_a), .frame_href(hr_a), .pix_valid(pv_a), .pix_data(pd_a),
    .busy(busy_a), .frame_done(fd_a));

  pixel_stream_gen #(.H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(HB_B), .V_BLANK(VB_B),
                     .VSYNC_CYC(VS), .DATA_WIDTH(8), .ADDR_WIDTH(19)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .cont(cont_b),
    .mem_rd_en(en_b), .mem_rd_addr(addr_b), .mem_rd_data(rdata_b),
    .frame_vsync(vs_b), .frame_href(hr_b), .pix_valid(pv_b), .pix_data(pd_b),
    .busy(busy_b), .frame_done(fd_b));

  // Synchronous single-port RAM models, one-cycle read latency.
  always_ff @(posedge clk) begin
    if (en_a) rdata_a <= (addr_a < 19'(NPIX)) ? ram_a[addr_a[3:0]] : 8'hEE;
    if (en_b) rdata_b <= (addr_b < 19'(NPIX)) ? ram_b[addr_b[3:0]] : 8'hEE;
  end

  // ---------------- reference model (frame geometry arithmetic) ----------------
  function automatic int hb_of(input int sel);
    return (sel != 0) ? HB_B : HB_A;
  endfunction
  function automatic int vb_of(input int sel);
    return (sel != 0) ? VB_B : VB_A;
  endfunction
  function automatic int period_of(input int sel);
    return VS + (vb_of(sel) + VP) * (HP + hb_of(sel)) + 1;
  endfunction
  // Pixel index shown at frame-relative cycle k, or -1 if no pixel is active.
  function automatic int pix_of(input int sel, input int k);
    int ln, j;
    ln = HP + hb_of(sel);
    j  = k - VS - vb_of(sel) * ln;
    if (k < VS || j < 0 || j >= VP * ln) return -1;
    if ((j % ln) >= HP) return -1;
    return (j / ln) * HP + (j % ln);
  endfunction
  function automatic logic [7:0] ram_rd(input int sel, input int idx);
    return (sel != 0) ? ram_b[idx] : ram_a[idx];
  endfunction
  // Expected {vsync, href, valid, done, data} at capture index i (outputs lag 2 cycles).
  function automatic logic [11:0] exp_out(input int sel, input int i, input int nfr);
    int k, p, idx;
    p = period_of(sel);
    k = i - 2;
    if (k < 0 || k >= nfr * p) return 12'h000;
    k = k % p;
    idx = pix_of(sel, k);
    return {(k < VS), (idx >= 0), (idx >= 0), (k == p - 1),
            (idx >= 0) ? ram_rd(sel, idx) : 8'h00};
  endfunction
  // Expected read index issued at capture index i (no lag), -1 if no read.
  function automatic int exp_rd(input int sel, input int i, input int nfr);
    int p;
    p = period_of(sel);
    if (i >= nfr * p) return -1;
    return pix_of(sel, i % p);
  endfunction

  // ---------------- stimulus / capture ----------------
  task automatic drive(input int sel, input logic s, input logic c, input logic r);
    if (sel == 0) begin start_a = s; cont_a = c; rst_a = r; end
    else          begin start_b = s; cont_b = c; rst_b = r; end
  endtask

  task automatic fill_ram(input int sel, input bit rnd);
    for (int j = 0; j < NPIX; j++) begin
      if (sel == 0) ram_a[j] = rnd ? 8'($urandom) : 8'(j + 16);
      else          ram_b[j] = rnd ? 8'($urandom) : 8'(j + 16);
    end
  endtask

  // Index 0 is the cycle right after the edge that samples start.
  task automatic capture(input int sel, input int n, input logic cont0,
                         input int start_at, input int drop_at, input int rst_at);
    @(negedge clk);
    drive(sel, 1'b1, cont0, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel == 0) begin
        o_vs[i] = vs_a; o_hr[i] = hr_a; o_pv[i] = pv_a; o_fd[i] = fd_a;
        o_pd[i] = pd_a; o_busy[i] = busy_a; o_en[i] = en_a; o_addr[i] = addr_a;
      end else begin
        o_vs[i] = vs_b; o_hr[i] = hr_b; o_pv[i] = pv_b; o_fd[i] = fd_b;
        o_pd[i] = pd_b; o_busy[i] = busy_b; o_en[i] = en_b; o_addr[i] = addr_b;
      end
      drive(sel, (i == start_at), cont0 && (i < drop_at), (i == rst_at));
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({vs_a, hr_a, pv_a, fd_a, busy_a, en_a, pd_a, addr_a} !== '0) begin
      errors++;
      $display("FAIL reset_a got %b/%h/%h want all zero", {vs_a, hr_a, pv_a, fd_a, busy_a, en_a}, pd_a, addr_a);
    end
    checks++;
    if ({vs_b, hr_b, pv_b, fd_b, busy_b, en_b, pd_b, addr_b} !== '0) begin
      errors++;
      $display("FAIL reset_b got %b/%h/%h want all zero", {vs_b, hr_b, pv_b, fd_b, busy_b, en_b}, pd_b, addr_b);
    end
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame(input int sel, input bit rnd);
    int p, n, idx, nd;
    logic [11:0] got, want;
    fill_ram(sel, rnd);
    p = period_of(sel);
    n = p + 6;
    capture(sel, n, 1'b0, -1, n, -1);
    nd = 0;
    for (int i = 0; i < n; i++) begin
      got  = {o_vs[i], o_hr[i], o_pv[i], o_fd[i], o_pd[i]};
      want = exp_out(sel, i, 1);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL frame_out sel=%0d i=%0d got %h want %h", sel, i, got, want);
      end
      checks++;
      if (o_busy[i] !== (i < p)) begin
        errors++;
        $display("FAIL frame_busy sel=%0d i=%0d got %b want %b", sel, i, o_busy[i], (i < p));
      end
      idx = exp_rd(sel, i, 1);
      checks++;
      if (o_en[i] !== (idx >= 0) || (idx >= 0 && o_addr[i] !== 19'(idx))) begin
        errors++;
        $display("FAIL frame_rd sel=%0d i=%0d got en=%b addr=%0d want en=%b addr=%0d",
                 sel, i, o_en[i], o_addr[i], (idx >= 0), idx);
      end
      if (o_fd[i] === 1'b1) nd++;
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL frame_done_count sel=%0d got %0d want 1", sel, nd);
    end
  endtask

  task automatic test_continuous(input int sel);
    int p, n, d, idx, r1, r2;
    logic [11:0] got, want;
    fill_ram(sel, 1'b1);
    p = period_of(sel);
    n = 2 * p + 6;
    d = $urandom_range(2 * p - 1, p);
    capture(sel, n, 1'b1, -1, d, -1);
    r1 = -1; r2 = -1;
    for (int i = 0; i < n; i++) begin
      got  = {o_vs[i], o_hr[i], o_pv[i], o_fd[i], o_pd[i]};
      want = exp_out(sel, i, 2);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cont_out sel=%0d i=%0d got %h want %h", sel, i, got, want);
      end
      idx = exp_rd(sel, i, 2);
      checks++;
      if (o_busy[i] !== (i < 2 * p) || o_en[i] !== (idx >= 0) ||
          (idx >= 0 && o_addr[i] !== 19'(idx))) begin
        errors++;
        $display("FAIL cont_ctl sel=%0d i=%0d got busy=%b en=%b addr=%0d want busy=%b en=%b addr=%0d",
                 sel, i, o_busy[i], o_en[i], o_addr[i], (i < 2 * p), (idx >= 0), idx);
      end
      if (i > 0 && o_vs[i] === 1'b1 && o_vs[i-1] === 1'b0) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
    end
    checks++;
    if (r1 < 0 || r2 < 0 || (r2 - r1) != p) begin
      errors++;
      $display("FAIL cont_period sel=%0d got %0d want %0d", sel, r2 - r1, p);
    end
  endtask

  task automatic test_start_while_busy();
    int p, n, sa, idx;
    logic [11:0] got, want;
    fill_ram(0, 1'b1);
    p  = period_of(0);
    n  = p + 6;
    sa = $urandom_range(p - 1, 1);
    capture(0, n, 1'b0, sa, n, -1);
    for (int i = 0; i < n; i++) begin
      got  = {o_vs[i], o_hr[i], o_pv[i], o_fd[i], o_pd[i]};
      want = exp_out(0, i, 1);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL busy_start_out at=%0d i=%0d got %h want %h", sa, i, got, want);
      end
      idx = exp_rd(0, i, 1);
      checks++;
      if (o_busy[i] !== (i < p) || o_en[i] !== (idx >= 0) ||
          (idx >= 0 && o_addr[i] !== 19'(idx))) begin
        errors++;
        $display("FAIL busy_start_ctl at=%0d i=%0d got busy=%b en=%b addr=%0d want busy=%b addr=%0d",
                 sa, i, o_busy[i], o_en[i], o_addr[i], (i < p), idx);
      end
    end
  endtask

  task automatic test_reset_mid_line();
    int r, n, idx;
    logic [11:0] got, want;
    fill_ram(0, 1'b0);
    // Output of line 1, pixel 2 appears 2 cycles after its state cycle.
    r = VS + VB_A * (HP + HB_A) + (HP + HB_A) + 2 + 2;
    n = r + 8;
    capture(0, n, 1'b0, -1, n, r);
    for (int i = 0; i < n; i++) begin
      got = {o_vs[i], o_hr[i], o_pv[i], o_fd[i], o_pd[i]};
      if (i <= r) begin
        want = exp_out(0, i, 1);
        idx  = exp_rd(0, i, 1);
        checks++;
        if (got !== want || o_busy[i] !== 1'b1 || o_en[i] !== (idx >= 0)) begin
          errors++;
          $display("FAIL rst_pre i=%0d got %h busy=%b en=%b want %h busy=1 en=%b",
                   i, got, o_busy[i], o_en[i], want, (idx >= 0));
        end
      end else begin
        checks++;
        if (got !== 12'h000 || o_busy[i] !== 1'b0 || o_en[i] !== 1'b0 || o_addr[i] !== 19'd0) begin
          errors++;
          $display("FAIL rst_post i=%0d got %h busy=%b en=%b addr=%0d want all zero",
                   i, got, o_busy[i], o_en[i], o_addr[i]);
        end
      end
    end
    test_single_frame(0, 1'b0);
  endtask

  task automatic test_latency_alignment();
    int n, first;
    fill_ram(0, 1'b1);
    n = period_of(0) + 4;
    capture(0, n, 1'b0, -1, n, -1);
    first = -1;
    for (int i = 0; i < n; i++) if (first < 0 && o_vs[i] === 1'b1) first = i;
    checks++;
    if (first != 2) begin
      errors++;
      $display("FAIL vsync_latency got %0d want 2", first);
    end
    for (int i = 0; i < n; i++) begin
      if (o_pv[i] === 1'b1) begin
        checks++;
        if (i < 2 || o_en[i-2] !== 1'b1 || o_pd[i] !== ram_a[o_addr[i-2][3:0]]) begin
          errors++;
          $display("FAIL align i=%0d got %h want RAM of addr issued 2 cycles earlier", i, o_pd[i]);
        end
      end else begin
        checks++;
        if (o_pd[i] !== 8'h00) begin
          errors++;
          $display("FAIL idle_data i=%0d got %h want 00", i, o_pd[i]);
        end
      end
    end
  endtask

  task automatic test_edge_params();
    int first;
    test_single_frame(1, 1'b0);
    first = -1;
    for (int i = 0; i < period_of(1) + 6; i++) if (first < 0 && o_hr[i] === 1'b1) first = i;
    checks++;
    if (first != VS + 2) begin
      errors++;
      $display("FAIL edge_first_href got %0d want %0d", first, VS + 2);
    end
    checks++;
    if (period_of(1) != 19 || o_fd[period_of(1) + 1] !== 1'b1) begin
      errors++;
      $display("FAIL edge_period got done=%b want done=1 at %0d", o_fd[period_of(1) + 1], period_of(1) + 1);
    end
    test_continuous(1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame(0, 1'b0);
    repeat (3) @(negedge clk);
    test_continuous(0);
    repeat (3) @(negedge clk);
    test_start_while_busy();
    repeat (3) @(negedge clk);
    test_reset_mid_line();
    repeat (3) @(negedge clk);
    test_latency_alignment();
    repeat (3) @(negedge clk);
    test_edge_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_gen.md
# pixel_stream_gen

Raster pixel-stream source for the image-processing chain. It reads a stored frame from a single-port synchronous frame RAM in raster order. It emits the vsync/href/valid/data stream that the 3x3 window line buffer and downstream filters consume, with programmable blanking. The stream has no backpressure, so the block must sustain one pixel per clock for every active line.

## Interface
Parameters:
- H_PIXEL, 640, active pixels per line (≤1024)
- V_PIXEL, 480, active lines per frame
- H_BLANK, 160, idle cycles after each active line (≥1)
- V_BLANK, 2, idle line periods (H_PIXEL+H_BLANK cycles each) between vsync and first active line
- VSYNC_CYC, 4, frame_vsync high duration in cycles (≥1)
- DATA_WIDTH, 8, pixel width
- ADDR_WIDTH, 19, frame RAM address width (must hold H_PIXEL*V_PIXEL-1)

Ports:
- clk  in  1  sole clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  level, sampled in IDLE only; begins a frame.
- cont  in  1  continuous mode. Sampled at the end of each frame.
- mem_rd_en  out  1  frame RAM read enable.
- mem_rd_addr  out  ADDR_WIDTH  frame RAM read address.
- mem_rd_data  in  DATA_WIDTH  RAM data, valid exactly 1 cycle after mem_rd_en.
- frame_vsync  out  1  frame start pulse.
- frame_href  out  1  high during active pixels.
- pix_valid  out  1  pixel qualifier (identical to frame_href).
- pix_data  out  DATA_WIDTH  pixel value; 0 when pix_valid low.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame leaves.

## Operation
- FSM states: IDLE, VSYNC, VBLANK, ACTIVE, HBLANK, DONE.
- IDLE → VSYNC when start=1. start in any other state is ignored.
- VSYNC lasts VSYNC_CYC cycles, then → VBLANK. If V_BLANK=0, → ACTIVE directly.
- VBLANK lasts V_BLANK*(H_PIXEL+H_BLANK) cycles, then → ACTIVE.
- ACTIVE lasts H_PIXEL cycles, then → HBLANK.
- HBLANK lasts H_BLANK cycles. At its end, → ACTIVE if lines sent < V_PIXEL, else → DONE.
- DONE lasts 1 cycle. Then → VSYNC if cont=1, else → IDLE. start is not required when continuing.
- In every ACTIVE cycle: mem_rd_en=1 and mem_rd_addr=pixel index. The index is a running counter, 0 at VSYNC entry, +1 per ACTIVE cycle, reaching H_PIXEL*V_PIXEL-1. No multiplier.
- mem_rd_en=0 outside ACTIVE. mem_rd_addr holds its last value.
- FSM-stage vsync, href and done flags are delayed 2 cycles so they align with the returned data:
  - stage 1 captures the flags and mem_rd_en;
  - stage 2 drives the outputs, with pix_data <= mem_rd_data when the stage-1 flag is set, else 0.
- Reset (any cycle, including mid-line):
  - next state IDLE, all counters 0, both pipeline stages cleared;
  - no partial pixel is emitted after reset.

## Timing
- Reset values: every output 0, including mem_rd_addr.
- Latency: for the edge sampling start=1 (edge 1), frame_vsync is first high after edge 3.
- Every output flag lags its FSM state by exactly 2 cycles.
- busy is not delayed: it rises after edge 1, and falls after the DONE→IDLE edge. busy can therefore fall 1 cycle before frame_done is seen. This is intentional; frame_done is the completion indicator.
- frame_vsync is high exactly VSYNC_CYC consecutive cycles per frame.
- frame_href/pix_valid are high exactly H_PIXEL consecutive cycles per line, and low ≥H_BLANK cycles between lines.
- Frame period = VSYNC_CYC + (V_BLANK+V_PIXEL)*(H_PIXEL+H_BLANK) + 1 cycles. In continuous mode frames are back-to-back with no extra gap.
- Read for pixel n is issued in cycle t. pix_data = RAM[n] with pix_valid high in cycle t+2.
- Counters are sized by $clog2 of their limits and must not overflow at the limits.

## Structure
- Shared package pixel_stream_pkg:
  - state enum (6 states, 3-bit);
  - localparams LINE_CYC = H_PIXEL+H_BLANK and FRAME_PIX = H_PIXEL*V_PIXEL.
- Sub-module raster_timing holds the FSM plus the col/line/blank/pixel-index counters. It outputs the stage-0 vsync/href/done flags and the read address.
- The top level holds the two pipeline stages and the output registers.

## Test plan
Small parameters throughout: H_PIXEL=4, V_PIXEL=3, H_BLANK=2, V_BLANK=1, VSYNC_CYC=3. RAM holds RAM[i]=i+16.
1. Single frame:
   - stimulus: start pulse, cont=0.
   - required: vsync high 3 cycles; then 6 idle cycles; then three 4-cycle href bursts of data 16–19, 20–23, 24–27, each followed by 2 low cycles; frame_done once; busy=0 afterwards; total 28 cycles.
2. Continuous:
   - stimulus: start with cont=1; drop cont during frame 2.
   - required: frames 1 and 2 back-to-back, 28-cycle period; frame 2 completes with correct data; busy=0 after frame 2; no frame 3.
3. Start while busy:
   - stimulus: pulse start mid-frame.
   - required: no restart, addresses continue monotonically, stream unchanged.
4. Reset mid-line:
   - stimulus: assert rst during pixel 2 of line 1.
   - required: all outputs 0 on the next cycle; no further pix_valid; next start produces a correct full frame starting at data 16.
5. Latency/alignment:
   - check frame_vsync first high after edge 3 counted from the start-sampling edge.
   - check every pix_valid cycle carries RAM[addr issued 2 cycles earlier].
   - check pix_data=0 whenever pix_valid=0.
6. Edge parameters:
   - stimulus: V_BLANK=0, H_BLANK=1.
   - required: first href directly 1+2 cycles after vsync ends; single-cycle gaps between lines; frame period 3+3*5+1=19 cycles.
